sram_rw_port_arbiter: RTL

- Shares the single read/write port (port 0) of the 32x512 OpenRAM program SRAM between two requesters: the management Wishbone slave (program load/readback) and a core-side requester (debug/self-modify path).
- Drives csb0/web0/wmask0/addr0/din0 and returns dout0 data with correct latency.
- Uses round-robin arbitration and one access in flight at a time.
- Sits in the user wrapper between the Wishbone bus, the core wrapper and the SRAM macro; port 1 (CPU fetch) is untouched.

---
 rtl/sram_rw_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sram_rw_port_arbiter.sv
// Round-robin arbiter for the program SRAM read/write port (port 0).
// Wishbone slave and core requester share it, one access in flight.
module sram_rw_port_arbiter #(
  parameter int          ADDR_W  = 9,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] WB_BASE = 32'h3000_0000,
  parameter int          RD_LAT  = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic [3:0]        core_wmask_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic [3:0]        sram_wmask_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_din_o,
  input  logic [DATA_W-1:0] sram_dout_i
);

  localparam int HI_W = 32 - (ADDR_W + 2);
  localparam logic [HI_W-1:0] BASE_HI = WB_BASE[31:ADDR_W+2];
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_e;

  state_e            state_q;
  logic              last_core_q;
  logic              wb_won_q;
  logic              we_q;
  logic [1:0]        cnt_q;
  logic [DATA_W-1:0] cap_q;

  logic              csb_q;
  logic              web_q;
  logic [3:0]        wmask_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              ack_q;
  logic [31:0]       wdat_q;
  logic              gnt_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic              adr_match_d;
  logic              wb_hit_d;
  logic              pick_core_d;
  logic              any_req_d;
  logic              sig_unused;

  assign sig_unused = ^wbs_adr_i[1:0];

  assign adr_match_d = wbs_adr_i[31:ADDR_W+2] == BASE_HI;

  // ack_q high means the master is still seeing its ack this cycle
  assign wb_hit_d = wbs_cyc_i & wbs_stb_i & adr_match_d
                  & ~ack_q & (state_q != ACK);

  assign pick_core_d = core_req_i & (~wb_hit_d | ~last_core_q);
  assign any_req_d   = wb_hit_d | core_req_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      last_core_q <= 1'b1;
      wb_won_q    <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      cap_q       <= '0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      ack_q       <= 1'b0;
      wdat_q      <= '0;
      gnt_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ack_q    <= 1'b0;
      wdat_q   <= '0;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req_d) begin
            state_q  <= ISSUE;
            csb_q    <= 1'b0;
            wb_won_q <= ~pick_core_d;
            if (pick_core_d) begin
              gnt_q   <= 1'b1;
              we_q    <= core_we_i;
              web_q   <= ~core_we_i;
              addr_q  <= core_addr_i;
              wmask_q <= core_we_i ? core_wmask_i : 4'h0;
              din_q   <= core_we_i ? core_wdata_i : '0;
            end else begin
              we_q    <= wbs_we_i;
              web_q   <= ~wbs_we_i;
              addr_q  <= wbs_adr_i[ADDR_W+1:2];
              wmask_q <= wbs_we_i ? wbs_sel_i : 4'h0;
              din_q   <= wbs_we_i ? DATA_W'(wbs_dat_i) : '0;
            end
          end
        end
        ISSUE: begin
          csb_q       <= 1'b1;
          web_q       <= 1'b1;
          last_core_q <= ~wb_won_q;
          if (we_q) begin
            state_q <= wb_won_q ? ACK : IDLE;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            cap_q <= sram_dout_i;
            if (wb_won_q) begin
              state_q <= ACK;
            end else begin
              state_q  <= IDLE;
              rvalid_q <= 1'b1;
              rdata_q  <= sram_dout_i;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= 1'b1;
          wdat_q  <= we_q ? 32'h0 : 32'(cap_q);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = wdat_q;
  assign core_gnt_o    = gnt_q;
  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;
  assign sram_csb_o    = csb_q;
  assign sram_web_o    = web_q;
  assign sram_wmask_o  = wmask_q;
  assign sram_addr_o   = addr_q;
  assign sram_din_o    = din_q;

endmodule
